// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: data width, byte-enable width, branch codes and
// the MEM-stage access state.
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_load_align.sv
// load_align: picks the full word or the addressed halfword of the load data,
// sign-extending halfwords.
`default_nettype none

module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic            addr_hi,
  input  logic            lh,
  output logic [XLEN-1:0] data
);

  logic [15:0] half;

  assign half = addr_hi ? rdata[31:16] : rdata[15:0];
  assign data = lh ? {{(XLEN-16){half[15]}}, half} : rdata;

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage -- data-memory handshake with bounded wait,
// upstream stall, branch resolution and the MEM/WB register.
`default_nettype none

module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            regWrite,
  input  logic            memtoReg,
  input  logic            memWrite,
  input  logic            sb,
  input  logic            lh,
  input  logic            zeroFlag,
  input  logic            halt,
  input  logic [1:0]      branch,
  input  logic [XLEN-1:0] readData2,
  input  logic [XLEN-1:0] ALUresult,
  input  logic [4:0]      rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [BE_W-1:0] dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            pcSrc,
  output logic            stall,
  output logic            wb_regWrite,
  output logic            wb_memtoReg,
  output logic            wb_halt,
  output logic [XLEN-1:0] wb_readData,
  output logic [XLEN-1:0] wb_ALUresult,
  output logic [4:0]      wb_rd,
  output logic            halted,
  output logic            bus_error
);

  localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             memop;
  logic             abandon;
  logic [XLEN-1:0]  load_data;

  assign memop = (memWrite | memtoReg) & ~halted;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abandon = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (memop && !dmem_ready) begin
          state_d = MEM_WAIT;
          cnt_d   = '0;
        end
      end
      MEM_WAIT: begin
        // A ready arriving on the limit cycle still completes the access.
        if (!memop || dmem_ready) begin
          state_d = MEM_IDLE;
        end else if (cnt_q == CNT_W'(WAIT_LIMIT)) begin
          abandon = 1'b1;
          state_d = MEM_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Request and stall are gated by reset so they fall as soon as reset asserts.
  assign dmem_req   = memop & reset_n;
  assign stall      = memop & ~dmem_ready & ~abandon & reset_n;
  assign dmem_we    = dmem_req & memWrite;
  assign dmem_addr  = {ALUresult[XLEN-1:2], 2'b00};
  assign dmem_wdata = (memWrite && sb) ? {4{readData2[7:0]}} : readData2;
  assign dmem_be    = (memWrite && sb) ? (BE_W'(1) << ALUresult[1:0]) : {BE_W{1'b1}};

  always_comb begin
    pcSrc = 1'b0;
    case (branch)
      BR_EQ:   pcSrc = zeroFlag;
      BR_NE:   pcSrc = ~zeroFlag;
      BR_JMP:  pcSrc = 1'b1;
      default: pcSrc = 1'b0;
    endcase
  end

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_hi (ALUresult[1]),
    .lh      (lh),
    .data    (load_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_regWrite  <= 1'b0;
      wb_memtoReg  <= 1'b0;
      wb_halt      <= 1'b0;
      wb_readData  <= '0;
      wb_ALUresult <= '0;
      wb_rd        <= '0;
      halted       <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      if (stall) begin
        wb_regWrite <= 1'b0;
        wb_memtoReg <= 1'b0;
        wb_halt     <= 1'b0;
      end else begin
        wb_regWrite <= regWrite & ~abandon;
        wb_memtoReg <= memtoReg;
        wb_halt     <= halt;
        if (halt) halted <= 1'b1;
      end
      wb_readData  <= load_data;
      wb_ALUresult <= ALUresult;
      wb_rd        <= rd;
      if (abandon) bus_error <= 1'b1;
    end
  end

endmodule

`default_nettype wire
